// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the multi-cycle control unit (master) and
// the data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              mem_read_flag;
    logic              mem_write_flag;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_read_flag, mem_write_flag, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read_flag, mem_write_flag, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word memory answering the control unit's level-held read/write
// flags: latch in IDLE, count down in BUSY, hold ready in DONE until flags drop.
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_wr;
    logic              r_both;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic          w_req;
    logic          w_bad;
    logic          w_fire;
    logic [AW-1:0] w_idx;

    assign w_req  = bus.mem_read_flag | bus.mem_write_flag;
    assign w_idx  = r_addr[AW+1:2];
    // Any set bit above the index field means the word address is >= DEPTH.
    assign w_bad  = (r_addr[1:0] != 2'b00) | (|r_addr[31:AW+2]) | r_both;
    assign w_fire = (r_state == S_BUSY) && (r_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wr    <= 1'b0;
            r_both  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_wr    <= bus.mem_write_flag;
                        r_both  <= bus.mem_read_flag & bus.mem_write_flag;
                        r_cnt   <= CNT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_err   <= w_bad;
                        if (!w_bad && !r_wr) r_rdata <= r_mem[w_idx];
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Flags must be seen low once before another request is taken.
                    if (!w_req) begin
                        r_ready <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; an async reset abandons the access
    // because the commit is gated on the BUSY state.
    always_ff @(posedge clk) begin
        if (w_fire && r_wr && !w_bad) r_mem[w_idx] <= r_wdata;
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.err   = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: two builds (LATENCY=2/DEPTH=256 and
// LATENCY=1/DEPTH=16) checked against a word-array reference model.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if #(.DATA_W(32)) if0 ();
    data_mem_responder_if #(.DATA_W(32)) if1 ();

    data_mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    data_mem_responder #(.DATA_W(32), .DEPTH(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mmem [2][256];
    logic [31:0] mrd [2];

    function automatic int depth_of(input int w); return (w == 0) ? 256 : 16; endfunction
    function automatic int lat_of(input int w); return (w == 0) ? 2 : 1; endfunction
    function automatic logic [31:0] o_rdata(input int w); return (w == 0) ? if0.rdata : if1.rdata; endfunction
    function automatic logic o_ready(input int w); return (w == 0) ? if0.ready : if1.ready; endfunction
    function automatic logic o_busy(input int w); return (w == 0) ? if0.busy : if1.busy; endfunction
    function automatic logic o_err(input int w); return (w == 0) ? if0.err : if1.err; endfunction

    task automatic drv(input int w, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (w == 0) begin
            if0.mem_read_flag = rd; if0.mem_write_flag = wr; if0.addr = a; if0.wdata = d;
        end else begin
            if1.mem_read_flag = rd; if1.mem_write_flag = wr; if1.addr = a; if1.wdata = d;
        end
    endtask

    // One complete request/response, starting just after a clock edge.
    task automatic access(input int w, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int hold, input bit drop, input string tag);
        int k;
        bit bad;
        bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'(depth_of(w))) || (rd && wr);
        if (!bad && wr) mmem[w][int'(a[31:2])] = d;
        if (!bad && rd) mrd[w] = mmem[w][int'(a[31:2])];
        drv(w, rd, wr, a, d);
        @(posedge clk); #1;
        vectors++;
        if ({o_busy(w), o_ready(w)} !== 2'b10) begin
            miscompares++;
            $display("FAIL %s dut%0d start: busy,ready=%b%b want 10", tag, w, o_busy(w), o_ready(w));
        end
        drv(w, drop ? 1'b0 : rd, drop ? 1'b0 : wr, $urandom, $urandom);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!o_ready(w) && k < 20);
        vectors++;
        if (k !== lat_of(w)) begin
            miscompares++;
            $display("FAIL %s dut%0d latency: got %0d want %0d", tag, w, k, lat_of(w));
        end
        vectors++;
        if ({o_busy(w), o_err(w)} !== {1'b0, bad}) begin
            miscompares++;
            $display("FAIL %s dut%0d err/busy: got %b%b want 0%b", tag, w, o_busy(w), o_err(w), bad);
        end
        vectors++;
        if (o_rdata(w) !== mrd[w]) begin
            miscompares++;
            $display("FAIL %s dut%0d rdata: got %h want %h", tag, w, o_rdata(w), mrd[w]);
        end
        if (!drop) begin
            for (int h = 0; h < hold; h++) begin
                drv(w, rd, wr, $urandom, $urandom);
                @(posedge clk); #1;
                vectors++;
                if ({o_ready(w), o_busy(w), o_err(w)} !== {2'b10, bad}) begin
                    miscompares++;
                    $display("FAIL %s dut%0d hold%0d: rdy,busy,err=%b%b%b", tag, w, h, o_ready(w), o_busy(w), o_err(w));
                end
            end
        end
        drv(w, 1'b0, 1'b0, $urandom, $urandom);
        @(posedge clk); #1;
        vectors++;
        if ({o_ready(w), o_busy(w), o_err(w)} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s dut%0d release: rdy,busy,err=%b%b%b want 000", tag, w, o_ready(w), o_busy(w), o_err(w));
        end
    endtask

    task automatic test_reset();
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        #12;
        for (int w = 0; w < 2; w++) begin
            vectors++;
            if ({o_ready(w), o_busy(w), o_err(w), o_rdata(w)} !== 35'd0) begin
                miscompares++;
                $display("FAIL reset dut%0d: rdy,busy,err=%b%b%b rdata=%h", w, o_ready(w), o_busy(w), o_err(w), o_rdata(w));
            end
            mrd[w] = 32'h0;
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < depth_of(w); i++)
                access(w, 0, 1, 32'(i * 4), $urandom, 0, 0, "fill");
    endtask

    task automatic test_write_read();
        for (int w = 0; w < 2; w++) begin
            access(w, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, "wr10");
            access(w, 1, 0, 32'h10, 32'h0, 0, 0, "rd10");
            vectors++;
            if (o_rdata(w) !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL rd10_const dut%0d: got %h want deadbeef", w, o_rdata(w));
            end
        end
    endtask

    task automatic test_held();
        access(0, 0, 1, 32'h80, 32'h1234_5678, 10, 0, "held_wr");
        access(0, 1, 0, 32'h80, 32'h0, 0, 0, "held_rd");
    endtask

    task automatic test_illegal();
        access(0, 1, 0, 32'h13, 32'h0, 1, 0, "misalign");
        access(0, 0, 1, 32'd1024, 32'hBAD0_0000, 0, 0, "oor_wr");
        access(0, 1, 0, 32'h0, 32'h0, 0, 0, "oor_w0");
        access(0, 1, 0, 32'd1020, 32'h0, 0, 0, "oor_wlast");
        access(1, 0, 1, 32'd64, 32'hBAD1_0000, 0, 0, "oor1_wr");
        access(1, 1, 0, 32'h0, 32'h0, 0, 0, "oor1_w0");
    endtask

    task automatic test_both_flags();
        access(0, 1, 1, 32'h20, 32'hFACE_FACE, 0, 0, "both");
        access(0, 1, 0, 32'h20, 32'h0, 0, 0, "both_rd");
    endtask

    task automatic test_reset_mid();
        drv(0, 0, 1, 32'h40, ~mmem[0][16]);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            vectors++;
            if ({o_ready(w), o_busy(w), o_err(w), o_rdata(w)} !== 35'd0) begin
                miscompares++;
                $display("FAIL rst_mid dut%0d: rdy,busy,err=%b%b%b rdata=%h", w, o_ready(w), o_busy(w), o_err(w), o_rdata(w));
            end
            mrd[w] = 32'h0;
        end
        drv(0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({o_ready(0), o_busy(0)} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_idle: rdy,busy=%b%b want 00", o_ready(0), o_busy(0));
        end
        access(0, 1, 0, 32'h40, 32'h0, 0, 0, "rst_rd");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 6; i++) begin
                a = 32'($urandom_range(0, depth_of(w) - 1) * 4);
                access(w, 0, 1, a, $urandom, 0, 0, "b2b_wr");
                access(w, 1, 0, a, $urandom, 0, 0, "b2b_rd");
            end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int sel, op;
        for (int i = 0; i < 120; i++) begin
            int w = i % 2;
            sel = $urandom_range(0, 9);
            op  = $urandom_range(0, 9);
            a = 32'($urandom_range(0, depth_of(w) - 1) * 4);
            if (sel == 0) a = a + 32'($urandom_range(1, 3));
            else if (sel == 1) a = 32'((depth_of(w) + $urandom_range(0, 1000)) * 4);
            access(w, op == 0 || op >= 5, op < 5, a, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3) == 0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_held();
        test_illegal();
        test_both_flags();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
